inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter: INST_WIDTH, 32, instruction word width.
REQ-002 Parameter: PC_WIDTH, 14, instruction address width (matches 14-bit jump target).
REQ-003 Parameter: DEPTH, 4, entry count; power of two, 2..16.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: fetch_valid  input  1  fetch stage offers an instruction.
REQ-007 Port: fetch_ready  output  1  queue accepts an instruction this cycle.
REQ-008 Port: fetch_inst  input  INST_WIDTH  fetched instruction bits.
REQ-009 Port: fetch_pc  input  PC_WIDTH  address of fetch_inst.
REQ-010 Port: fetch_pred_taken  input  1  fetch predicted the branch taken.
REQ-011 Port: issue_valid  output  1  head entry is presented to decode/issue.
REQ-012 Port: issue_ready  input  1  decode/issue consumes the head entry.
REQ-013 Port: issue_inst  output  INST_WIDTH  head instruction bits, feed to inst_if.bits.
REQ-014 Port: issue_pc  output  PC_WIDTH  head instruction address.
REQ-015 Port: issue_pred_taken  output  1  head prediction bit.
REQ-016 Port: flush  input  1  misprediction/redirect; discard all entries.
REQ-017 Port: count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-018 Storage: circular buffer of DEPTH entries {inst, pc, pred_taken}; head/tail pointers $clog2(DEPTH) bits, wrap modulo DEPTH.
REQ-019 Push: fetch_valid && fetch_ready at a rising edge writes the entry at tail and advances tail by 1.
REQ-020 Pop: issue_valid && issue_ready at a rising edge advances head by 1.
REQ-021 fetch_ready = (count != DEPTH); it depends on registered state only, never on issue_ready (no full-queue pass-through).
REQ-022 issue_valid = (count != 0); issue_inst/pc/pred_taken are driven from the head entry combinationally (first-word fall-through).
REQ-023 Latency: an entry pushed in cycle N is visible on issue_* in cycle N+1 at the earliest.
REQ-024 Simultaneous push and pop with 0 < count < DEPTH: both pointers advance; count unchanged.
REQ-025 Full (count == DEPTH): push is refused; a pop still succeeds, and fetch_ready rises the following cycle.
REQ-026 Empty (count == 0): a pop is impossible because issue_valid = 0; issue_ready is ignored.
REQ-027 Issue outputs stay stable while issue_valid && !issue_ready.
REQ-028 Flush has priority over push and pop in the same cycle: next cycle count = 0 and head = tail = 0, and the concurrent fetch word is dropped.
REQ-029 During a flush cycle, fetch_ready and issue_valid keep their registered values; the flush takes effect at the edge.
REQ-030 count is always tail-minus-head occupancy in 0..DEPTH, tracked in a separate register so full and empty are distinguished when head == tail.
REQ-031 issue_* data while issue_valid = 0 is don't-care and must not be relied on.

Reset
REQ-032 reset = 1 at a rising edge: head = 0, tail = 0, count = 0; then issue_valid = 0 and fetch_ready = 1.
REQ-033 Reset overrides flush, push and pop in the same cycle.
REQ-034 Entry storage is not cleared by reset.
REQ-035 Reset asserted mid-stream discards all entries; the first push after reset lands in entry 0.

Verification
REQ-036 After reset, push 0x0C000005 at pc 0x0010, no pop -> next cycle issue_valid = 1, issue_inst = 0x0C000005, issue_pc = 0x0010, count = 1.
REQ-037 Push 4 words with issue_ready = 0 -> count = 4 and fetch_ready = 0. A fifth push is refused. One pop then gives fetch_ready = 1 the next cycle, and output order matches push order.
REQ-038 Continuous push and pop with count = 2 for 10 cycles -> count stays 2, pointers wrap past 3 to 0, no data loss or duplication.
REQ-039 Queue holds 3 entries; assert flush together with a push and a pop -> next cycle count = 0, issue_valid = 0, and the pushed word never appears.
REQ-040 Queue holds 2 entries; assert reset and flush together -> next cycle count = 0 and fetch_ready = 1. The next push (pc 0x0100) appears on issue_pc = 0x0100.
REQ-041 Hold issue_ready = 0 with a valid head for 5 cycles while pushing -> issue_inst, issue_pc and issue_pred_taken stay unchanged each cycle.

Source files
------------

// File: rtl/inst_queue.sv
// ---------------------------------------------------------------------------
// inst_queue
//
// Purpose
//   Instruction queue that decouples the fetch stage from decode/issue.
//   It is a circular buffer of DEPTH entries. Each entry holds
//   {instruction bits, instruction address, predicted-taken bit}.
//   The head entry is presented combinationally (first-word fall-through),
//   so a word pushed in cycle N can be issued in cycle N+1.
//
// Handshake (both sides)
//   A transfer happens at a rising clock edge exactly when valid && ready
//   are both high at that edge. A producer that raises valid keeps the
//   payload stable until the transfer. ready never depends combinationally
//   on the other side's valid/ready:
//     fetch_ready = (count != DEPTH)  -- registered state only, so a full
//                                        queue never passes a word through
//     issue_valid = (count != 0)      -- registered state only
//
// Ports
//   clk              in   1           single clock, rising edge
//   reset            in   1           synchronous, active-high
//   fetch_valid      in   1           fetch offers a word
//   fetch_ready      out  1           queue can accept a word this cycle
//   fetch_inst       in   INST_WIDTH  fetched instruction bits
//   fetch_pc         in   PC_WIDTH    address of fetch_inst
//   fetch_pred_taken in   1           fetch predicted the branch taken
//   issue_valid      out  1           head entry is valid
//   issue_ready      in   1           decode/issue consumes the head
//   issue_inst       out  INST_WIDTH  head instruction bits
//   issue_pc         out  PC_WIDTH    head instruction address
//   issue_pred_taken out  1           head prediction bit
//   flush            in   1           discard every entry (redirect)
//   count            out  CNT_W       current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module inst_queue #(
    parameter int INST_WIDTH = 32,
    parameter int PC_WIDTH   = 14,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fetch_valid,
    output logic                       fetch_ready,
    input  logic [INST_WIDTH-1:0]      fetch_inst,
    input  logic [PC_WIDTH-1:0]        fetch_pc,
    input  logic                       fetch_pred_taken,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [INST_WIDTH-1:0]      issue_inst,
    output logic [PC_WIDTH-1:0]        issue_pc,
    output logic                       issue_pred_taken,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Occupancy value meaning "every entry is in use".
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // -----------------------------------------------------------------------
    // Storage. Deliberately left out of reset: the pointers and the
    // occupancy counter alone decide which entries are meaningful.
    // -----------------------------------------------------------------------
    logic [INST_WIDTH-1:0] r_inst_mem [DEPTH];
    logic [PC_WIDTH-1:0]   r_pc_mem   [DEPTH];
    logic                  r_pred_mem [DEPTH];

    // Pointers are exactly PTR_W bits wide; because DEPTH is a power of
    // two the natural binary roll-over implements the modulo-DEPTH wrap.
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;

    // Occupancy is kept in its own register so that head == tail can be
    // told apart as either empty (count 0) or full (count DEPTH).
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // -----------------------------------------------------------------------
    // Handshake qualification
    // -----------------------------------------------------------------------
    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);

    // Both ready/valid come from registered state only. During a flush or
    // reset cycle they therefore still show the pre-edge occupancy; the
    // discard happens at the edge.
    assign fetch_ready = !w_full;
    assign issue_valid = !w_empty;

    // A push while full is refused even if the head is popped in the same
    // cycle (no pass-through); a pop while empty cannot happen because
    // issue_valid is low, so issue_ready is ignored then.
    assign w_push = fetch_valid && fetch_ready;
    assign w_pop  = issue_valid && issue_ready;

    // -----------------------------------------------------------------------
    // Pointer and occupancy update. Reset beats flush, flush beats any
    // concurrent push or pop.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Entry write. A word offered in a flush or reset cycle is dropped; it
    // would be unreachable anyway once the pointers return to zero, but not
    // writing it keeps the storage contents easier to reason about.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push && !reset && !flush) begin
            r_inst_mem[r_tail] <= fetch_inst;
            r_pc_mem[r_tail]   <= fetch_pc;
            r_pred_mem[r_tail] <= fetch_pred_taken;
        end
    end

    // -----------------------------------------------------------------------
    // First-word fall-through read of the head entry. The values are only
    // meaningful while issue_valid is high; they do not change while the
    // head is stalled because r_head and the head entry are not written
    // then (a push always targets the tail, which differs from the head
    // whenever the queue is non-empty and not full).
    // -----------------------------------------------------------------------
    assign issue_inst       = r_inst_mem[r_head];
    assign issue_pc         = r_pc_mem[r_head];
    assign issue_pred_taken = r_pred_mem[r_head];

    assign count = r_count;

endmodule

// File: tb/tb_inst_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_queue
//
// Self-checking bench for inst_queue (default parameters: 32/14/4).
// Inputs are driven 1 time unit after a rising edge; outputs are sampled
// 1 time unit after the next rising edge. A reference queue (exp_q) holds
// the words the bench expects to be in the design: a word is pushed when
// the bench drives an accepted fetch, popped when it drives an accepted
// issue, and the head is compared against issue_* every cycle.
// ---------------------------------------------------------------------------
module tb_inst_queue;

  localparam int INST_WIDTH = 32;
  localparam int PC_WIDTH   = 14;
  localparam int DEPTH      = 4;
  localparam int CNT_W      = $clog2(DEPTH) + 1;
  localparam int ENT_W      = 1 + PC_WIDTH + INST_WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic                  fetch_valid;
  logic                  fetch_ready;
  logic [INST_WIDTH-1:0] fetch_inst;
  logic [PC_WIDTH-1:0]   fetch_pc;
  logic                  fetch_pred_taken;
  logic                  issue_valid;
  logic                  issue_ready;
  logic [INST_WIDTH-1:0] issue_inst;
  logic [PC_WIDTH-1:0]   issue_pc;
  logic                  issue_pred_taken;
  logic                  flush;
  logic [CNT_W-1:0]      count;

  inst_queue #(
    .INST_WIDTH(INST_WIDTH),
    .PC_WIDTH  (PC_WIDTH),
    .DEPTH     (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_valid     (fetch_valid),
    .fetch_ready     (fetch_ready),
    .fetch_inst      (fetch_inst),
    .fetch_pc        (fetch_pc),
    .fetch_pred_taken(fetch_pred_taken),
    .issue_valid     (issue_valid),
    .issue_ready     (issue_ready),
    .issue_inst      (issue_inst),
    .issue_pc        (issue_pc),
    .issue_pred_taken(issue_pred_taken),
    .flush           (flush),
    .count           (count)
  );

  // ---------------- scoreboard ----------------
  logic [ENT_W-1:0] exp_q[$];   // {pred, pc, inst}
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare occupancy/handshake outputs and the head entry with exp_q.
  task automatic check_state(input string tag);
    logic [ENT_W-1:0] head;
    check({tag, ".count"}, 64'(count), 64'(exp_q.size()));
    check({tag, ".fetch_ready"}, 64'(fetch_ready), 64'(exp_q.size() != DEPTH));
    check({tag, ".issue_valid"}, 64'(issue_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check({tag, ".issue_head"}, 64'({issue_pred_taken, issue_pc, issue_inst}), 64'(head));
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive inputs, advance the reference model with the
  // pre-edge occupancy, wait for the edge, then check.
  task automatic cycle(input logic rst, input logic fl, input logic fv,
                       input logic [INST_WIDTH-1:0] inst, input logic [PC_WIDTH-1:0] pc,
                       input logic pred, input logic ir, input string tag);
    int sz;
    reset            = rst;
    flush            = fl;
    fetch_valid      = fv;
    fetch_inst       = inst;
    fetch_pc         = pc;
    fetch_pred_taken = pred;
    issue_ready      = ir;
    sz = exp_q.size();
    if (rst || fl) begin
      exp_q.delete();
    end else begin
      if (ir && sz != 0) void'(exp_q.pop_front());
      if (fv && sz != DEPTH) exp_q.push_back({pred, pc, inst});
    end
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, tag);
  endtask

  task automatic push(input logic [INST_WIDTH-1:0] inst, input logic [PC_WIDTH-1:0] pc,
                      input logic pred, input string tag);
    cycle(1'b0, 1'b0, 1'b1, inst, pc, pred, 1'b0, tag);
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic                  rst;
    logic                  fl;
    logic                  fv;
    logic [INST_WIDTH-1:0] inst;
    logic [PC_WIDTH-1:0]   pc;
    logic                  pred;
    logic                  ir;
    int                    exp_count;   // after the edge
    logic                  exp_fready;
    logic                  exp_ivalid;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [INST_WIDTH-1:0] hold_inst;
    logic [PC_WIDTH-1:0]   hold_pc;
    logic                  hold_pred;

    reset = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_inst = '0;
    fetch_pc = '0; fetch_pred_taken = 1'b0; issue_ready = 1'b0;

    //           rst  fl   fv   inst          pc        pred ir   cnt fr  iv
    vecs[0]  = '{1'b1,1'b0,1'b0,32'h0,        14'h0,    1'b0,1'b0,0, 1'b1,1'b0};
    vecs[1]  = '{1'b0,1'b0,1'b1,32'h0C000005, 14'h0010, 1'b0,1'b0,1, 1'b1,1'b1};
    vecs[2]  = '{1'b0,1'b0,1'b1,32'hA0000001, 14'h0014, 1'b1,1'b0,2, 1'b1,1'b1};
    vecs[3]  = '{1'b0,1'b0,1'b1,32'hA0000002, 14'h0018, 1'b0,1'b0,3, 1'b1,1'b1};
    vecs[4]  = '{1'b0,1'b0,1'b1,32'hA0000003, 14'h001C, 1'b1,1'b0,4, 1'b0,1'b1};
    vecs[5]  = '{1'b0,1'b0,1'b1,32'hBAD00005, 14'h0020, 1'b0,1'b0,4, 1'b0,1'b1};
    // Full: push refused, pop accepted in the same cycle.
    vecs[6]  = '{1'b0,1'b0,1'b1,32'hBAD00006, 14'h0024, 1'b1,1'b1,3, 1'b1,1'b1};
    vecs[7]  = '{1'b0,1'b0,1'b0,32'h0,        14'h0,    1'b0,1'b1,2, 1'b1,1'b1};
    vecs[8]  = '{1'b0,1'b0,1'b0,32'h0,        14'h0,    1'b0,1'b1,1, 1'b1,1'b1};
    vecs[9]  = '{1'b0,1'b0,1'b0,32'h0,        14'h0,    1'b0,1'b1,0, 1'b1,1'b0};
    // Empty: issue_ready ignored.
    vecs[10] = '{1'b0,1'b0,1'b0,32'h0,        14'h0,    1'b0,1'b1,0, 1'b1,1'b0};
    // Reset overrides a concurrent push.
    vecs[11] = '{1'b1,1'b0,1'b1,32'hDEAD0001, 14'h0030, 1'b0,1'b0,0, 1'b1,1'b0};

    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].rst, vecs[i].fl, vecs[i].fv, vecs[i].inst, vecs[i].pc,
            vecs[i].pred, vecs[i].ir, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.tbl_count", i), 64'(count), 64'(vecs[i].exp_count));
      check($sformatf("vec%0d.tbl_fready", i), 64'(fetch_ready), 64'(vecs[i].exp_fready));
      check($sformatf("vec%0d.tbl_ivalid", i), 64'(issue_valid), 64'(vecs[i].exp_ivalid));
      if (i == 1) begin
        check("vec1.issue_inst", 64'(issue_inst), 64'h0C000005);
        check("vec1.issue_pc", 64'(issue_pc), 64'h0010);
      end
    end

    // ---- steady push+pop at count 2, pointers wrap several times ----
    push(32'h11110000, 14'h0100, 1'b0, "wrap_fill0");
    push(32'h11110001, 14'h0104, 1'b1, "wrap_fill1");
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 1'b1, $urandom(), 14'($urandom_range(0, 16383)),
            1'($urandom_range(0, 1)), 1'b1, $sformatf("wrap%0d", i));
      check($sformatf("wrap%0d.count2", i), 64'(count), 64'd2);
    end
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, "wrap_drain0");
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, "wrap_drain1");
    check("wrap_drain.empty", 64'(issue_valid), 64'd0);

    // ---- flush with concurrent push and pop while holding 3 ----
    push(32'h22220000, 14'h0200, 1'b0, "fl_fill0");
    push(32'h22220001, 14'h0204, 1'b0, "fl_fill1");
    push(32'h22220002, 14'h0208, 1'b1, "fl_fill2");
    cycle(1'b0, 1'b1, 1'b1, 32'hF1F1F1F1, 14'h0ABC, 1'b1, 1'b1, "flush");
    check("flush.count0", 64'(count), 64'd0);
    check("flush.ivalid0", 64'(issue_valid), 64'd0);
    idle("flush_idle");
    check("flush_idle.ivalid0", 64'(issue_valid), 64'd0);
    push(32'h33330000, 14'h0300, 1'b1, "after_flush");
    check("after_flush.pc", 64'(issue_pc), 64'h0300);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, "after_flush_pop");

    // ---- reset and flush together with 2 held ----
    push(32'h44440000, 14'h0400, 1'b0, "rf_fill0");
    push(32'h44440001, 14'h0404, 1'b0, "rf_fill1");
    cycle(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, "rst_flush");
    check("rst_flush.count0", 64'(count), 64'd0);
    check("rst_flush.fready1", 64'(fetch_ready), 64'd1);
    push(32'h55550000, 14'h0100, 1'b0, "rst_push");
    check("rst_push.pc", 64'(issue_pc), 64'h0100);
    check("rst_push.inst", 64'(issue_inst), 64'h55550000);

    // ---- stalled head stays stable while pushes continue ----
    hold_inst = 32'h55550000; hold_pc = 14'h0100; hold_pred = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(32'h66660000 + i, 14'h0600 + 14'(i), 1'(i), $sformatf("stall%0d", i));
      check($sformatf("stall%0d.inst", i), 64'(issue_inst), 64'(hold_inst));
      check($sformatf("stall%0d.pc", i), 64'(issue_pc), 64'(hold_pc));
      check($sformatf("stall%0d.pred", i), 64'(issue_pred_taken), 64'(hold_pred));
    end

    // ---- random traffic ----
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 4),
            1'($urandom_range(0, 99) < 60), $urandom(), 14'($urandom_range(0, 16383)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 50),
            $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
